// File: rtl/axi_lite_pkg.sv
// Shared definitions for the Avalon-MM to AXI4-Lite bridge:
// FSM state encoding, AXI response codes and the default PROT value.
package axi_lite_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StWrB,
        StRdA,
        StRdD,
        StAck
    } state_e;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespExokay = 2'b01;
    localparam logic [1:0] RespSlverr = 2'b10;
    localparam logic [1:0] RespDecerr = 2'b11;

    localparam logic [2:0] ProtDefault = 3'b000;

endpackage

// File: rtl/axi_lite_bridge_master_if.sv
// AXI4-Lite channel bundle with master and slave views.
interface axi_lite_bridge_master_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
);
    logic [AddrWidth-1:0]   awaddr;
    logic [2:0]             awprot;
    logic                   awvalid;
    logic                   awready;
    logic [DataWidth-1:0]   wdata;
    logic [DataWidth/8-1:0] wstrb;
    logic                   wvalid;
    logic                   wready;
    logic [1:0]             bresp;
    logic                   bvalid;
    logic                   bready;
    logic [AddrWidth-1:0]   araddr;
    logic [2:0]             arprot;
    logic                   arvalid;
    logic                   arready;
    logic [DataWidth-1:0]   rdata;
    logic [1:0]             rresp;
    logic                   rvalid;
    logic                   rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

endinterface

// File: rtl/axi_lite_err_counter.sv
// Sticky error flag plus saturating error counter; clear beats a same-cycle increment.
module axi_lite_err_counter #(
    parameter int unsigned CntWidth = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                err_inc,
    input  logic                err_clr,
    output logic                err_sticky,
    output logic [CntWidth-1:0] err_count
);

    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else if (err_inc) begin
            err_sticky <= 1'b1;
            if (err_count != '1) begin
                err_count <= err_count + CntWidth'(1);
            end
        end
    end

endmodule

// File: rtl/axi_lite_bridge_master.sv
// Avalon-MM slave to AXI4-Lite master bridge with one transaction outstanding.
// The command is captured on leaving IDLE and acknowledged for a single ACK cycle.
module axi_lite_bridge_master
    import axi_lite_pkg::*;
#(
    parameter int unsigned                   C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned                   C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = '0,
    parameter logic [C_M_AXI_DATA_WIDTH-1:0] C_ERR_DATA         =
        {(C_M_AXI_DATA_WIDTH / 32){32'hDEAD_BEEF}},
    parameter int unsigned                   C_ERR_CNT_WIDTH    = 8
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESET,
    input  logic                            avalonRead,
    input  logic                            avalonWrite,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   avalonAddr,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] avalonBE,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   avalonWriteData,
    output logic                            avalonWaitReq,
    output logic                            avalonReadValid,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   avalonReadData,
    output logic [1:0]                      avalonResp,
    output logic                            errSticky,
    output logic [C_ERR_CNT_WIDTH-1:0]      errCount,
    input  logic                            errClear,
    axi_lite_bridge_master_if.master        m_axi
);

    localparam int unsigned StrbWidth = C_M_AXI_DATA_WIDTH / 8;
    localparam int unsigned LsbBits   = $clog2(StrbWidth);

    state_e                        state_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr_aligned;
    logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q;
    logic [C_M_AXI_DATA_WIDTH-1:0] rdata_q;
    logic [StrbWidth-1:0]          wstrb_q;
    logic                          awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic                          waitreq_q, readvalid_q;
    logic [1:0]                    resp_q;
    logic                          aw_done, w_done;
    logic                          err_inc;

    always_comb begin
        // Offset wraps at the address width; sub-word address bits are dropped.
        addr_aligned = avalonAddr + C_BASE_ADDR;
        addr_aligned[LsbBits-1:0] = '0;
        aw_done = !awvalid_q || m_axi.awready;
        w_done  = !wvalid_q || m_axi.wready;
        err_inc = (state_q == StAck) && (resp_q != RespOkay);
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            resp_q      <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            waitreq_q   <= 1'b1;
            readvalid_q <= 1'b0;
        end else begin
            waitreq_q   <= 1'b1;
            readvalid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (avalonWrite || avalonRead) begin
                        addr_q  <= addr_aligned;
                        wstrb_q <= avalonBE;
                        wdata_q <= avalonWriteData;
                    end
                    if (avalonWrite) begin
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        state_q   <= StWr;
                    end else if (avalonRead) begin
                        arvalid_q <= 1'b1;
                        state_q   <= StRdA;
                    end
                end
                StWr: begin
                    if (awvalid_q && m_axi.awready) awvalid_q <= 1'b0;
                    if (wvalid_q && m_axi.wready) wvalid_q <= 1'b0;
                    if (aw_done && w_done) begin
                        bready_q <= 1'b1;
                        state_q  <= StWrB;
                    end
                end
                StWrB: begin
                    if (m_axi.bvalid) begin
                        resp_q    <= m_axi.bresp;
                        bready_q  <= 1'b0;
                        waitreq_q <= 1'b0;
                        state_q   <= StAck;
                    end
                end
                StRdA: begin
                    if (m_axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= StRdD;
                    end
                end
                StRdD: begin
                    if (m_axi.rvalid) begin
                        resp_q      <= m_axi.rresp;
                        rdata_q     <= (m_axi.rresp == RespOkay) ? m_axi.rdata : C_ERR_DATA;
                        rready_q    <= 1'b0;
                        waitreq_q   <= 1'b0;
                        readvalid_q <= 1'b1;
                        state_q     <= StAck;
                    end
                end
                StAck:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    axi_lite_err_counter #(
        .CntWidth (C_ERR_CNT_WIDTH)
    ) u_err_counter (
        .clk        (M_AXI_ACLK),
        .rst        (M_AXI_ARESET),
        .err_inc    (err_inc),
        .err_clr    (errClear),
        .err_sticky (errSticky),
        .err_count  (errCount)
    );

    assign m_axi.awaddr  = addr_q;
    assign m_axi.awprot  = ProtDefault;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arprot  = ProtDefault;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

    assign avalonWaitReq   = waitreq_q;
    assign avalonReadValid = readvalid_q;
    assign avalonReadData  = rdata_q;
    assign avalonResp      = resp_q;

endmodule

// File: tb/tb_axi_lite_bridge_master.sv
// Self-checking bench: table of directed transfers, random transfers against a transfer-level
// model, and hand sequences for back-to-back, saturation/clear, reset abort and 64-bit wrap.
module tb_axi_lite_bridge_master;
    import axi_lite_pkg::*;

    localparam logic [31:0] Base = 32'hC700_0000;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        int          awd, wd, bd, ard, rd;
        logic [1:0]  rsp;
        logic [31:0] rdat;
        logic [31:0] exp_addr;
        int          exp_lat;
        logic [31:0] exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        avalonRead, avalonWrite, errClear;
    logic [31:0] avalonAddr, avalonWriteData;
    logic [3:0]  avalonBE;
    logic        waitreq, readvalid, err_sticky;
    logic [31:0] readdata;
    logic [1:0]  resp;
    logic [7:0]  err_count;

    axi_lite_bridge_master_if #(.AddrWidth(32), .DataWidth(32)) axi ();

    axi_lite_bridge_master #(
        .C_BASE_ADDR (Base)
    ) dut (
        .M_AXI_ACLK      (clk),
        .M_AXI_ARESET    (rst),
        .avalonRead      (avalonRead),
        .avalonWrite     (avalonWrite),
        .avalonAddr      (avalonAddr),
        .avalonBE        (avalonBE),
        .avalonWriteData (avalonWriteData),
        .avalonWaitReq   (waitreq),
        .avalonReadValid (readvalid),
        .avalonReadData  (readdata),
        .avalonResp      (resp),
        .errSticky       (err_sticky),
        .errCount        (err_count),
        .errClear        (errClear),
        .m_axi           (axi)
    );

    // 64-bit instance with a wrapping base and an always-ready slave.
    logic        rd2, wait2, rv2, st2;
    logic [31:0] addr2;
    logic [63:0] rdata2;
    logic [1:0]  resp2;
    logic [7:0]  cnt2;
    axi_lite_bridge_master_if #(.AddrWidth(32), .DataWidth(64)) axi2 ();
    assign axi2.awready = 1'b1;
    assign axi2.wready  = 1'b1;
    assign axi2.bvalid  = 1'b1;
    assign axi2.bresp   = RespOkay;
    assign axi2.arready = 1'b1;
    assign axi2.rvalid  = 1'b1;
    assign axi2.rresp   = RespOkay;
    assign axi2.rdata   = 64'h0123_4567_89AB_CDEF;

    axi_lite_bridge_master #(
        .C_M_AXI_DATA_WIDTH (64),
        .C_BASE_ADDR        (32'hFFFF_FFF0)
    ) dut2 (
        .M_AXI_ACLK      (clk),
        .M_AXI_ARESET    (rst),
        .avalonRead      (rd2),
        .avalonWrite     (1'b0),
        .avalonAddr      (addr2),
        .avalonBE        (8'hFF),
        .avalonWriteData (64'h0),
        .avalonWaitReq   (wait2),
        .avalonReadValid (rv2),
        .avalonReadData  (rdata2),
        .avalonResp      (resp2),
        .errSticky       (st2),
        .errCount        (cnt2),
        .errClear        (1'b0),
        .m_axi           (axi2)
    );

    int total = 0;
    int bad = 0;
    int m_cnt = 0;
    bit m_st = 1'b0;

    // Slave model configuration and observations.
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic [1:0]  resp_cfg;
    logic [31:0] rdata_cfg;
    int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
    bit          aw_got, w_got, ar_got, b_hs, r_hs, pv_aw, pv_w, pv_ar;
    int          n_aw, n_w, n_b, n_ar, n_r;
    int          viol = 0;
    logic [31:0] rec_addr, rec_wdata;
    logic [3:0]  rec_wstrb;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Slave acts on the falling edge; whatever it drives is what the next rising edge samples.
    initial begin : axi_slave
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = '0;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rresp = '0; axi.rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
                axi.arready = 1'b0; axi.rvalid = 1'b0;
                aw_got = 0; w_got = 0; ar_got = 0; b_hs = 0; r_hs = 0;
                aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
                pv_aw = 0; pv_w = 0; pv_ar = 0;
            end else begin
                if ((pv_aw && !axi.awvalid) || (pv_w && !axi.wvalid) || (pv_ar && !axi.arvalid))
                    viol++;
                if (b_hs) begin axi.bvalid = 1'b0; b_hs = 0; n_b++; end
                if (!axi.bvalid && aw_got && w_got) begin
                    if (b_wait >= b_dly) begin
                        axi.bvalid = 1'b1; axi.bresp = resp_cfg;
                        aw_got = 0; w_got = 0; b_wait = 0;
                    end else b_wait++;
                end
                b_hs = axi.bvalid && axi.bready;
                if (r_hs) begin axi.rvalid = 1'b0; r_hs = 0; n_r++; end
                if (!axi.rvalid && ar_got) begin
                    if (r_wait >= r_dly) begin
                        axi.rvalid = 1'b1; axi.rresp = resp_cfg; axi.rdata = rdata_cfg;
                        ar_got = 0; r_wait = 0;
                    end else r_wait++;
                end
                r_hs = axi.rvalid && axi.rready;
                axi.awready = axi.awvalid && (aw_wait >= aw_dly);
                if (axi.awready) begin rec_addr = axi.awaddr; aw_got = 1; aw_wait = 0; n_aw++; end
                else if (axi.awvalid) aw_wait++;
                pv_aw = axi.awvalid && !axi.awready;
                axi.wready = axi.wvalid && (w_wait >= w_dly);
                if (axi.wready) begin
                    rec_wdata = axi.wdata; rec_wstrb = axi.wstrb; w_got = 1; w_wait = 0; n_w++;
                end else if (axi.wvalid) w_wait++;
                pv_w = axi.wvalid && !axi.wready;
                axi.arready = axi.arvalid && (ar_wait >= ar_dly);
                if (axi.arready) begin rec_addr = axi.araddr; ar_got = 1; ar_wait = 0; n_ar++; end
                else if (axi.arvalid) ar_wait++;
                pv_ar = axi.arvalid && !axi.arready;
            end
        end
    end

    // Transfer-level reference: aligned wrapped address, latency from slave delays, error data.
    function automatic vec_t with_expect(input vec_t v);
        vec_t r = v;
        int   wmax = (v.awd > v.wd) ? v.awd : v.wd;
        r.exp_addr  = (v.addr + Base) & 32'hFFFF_FFFC;
        r.exp_lat   = v.is_wr ? (wmax + v.bd + 4) : (v.ard + v.rd + 4);
        r.exp_rdata = (v.rsp == RespOkay) ? v.rdat : 32'hDEAD_BEEF;
        return r;
    endfunction

    task automatic apply(input vec_t v, input bit clr, input string tag);
        int          cyc = 0;
        bit          acked = 0;
        logic        rv = 1'b0;
        logic [31:0] rdat = '0;
        logic [1:0]  rsp = '0;
        aw_dly = v.awd; w_dly = v.wd; b_dly = v.bd; ar_dly = v.ard; r_dly = v.rd;
        resp_cfg = v.rsp; rdata_cfg = v.rdat;
        n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
        rec_addr = 'x; rec_wdata = 'x; rec_wstrb = 'x;
        avalonWrite = v.is_wr; avalonRead = !v.is_wr;
        avalonAddr = v.addr; avalonWriteData = v.data; avalonBE = v.be;
        while (!acked && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (!waitreq) begin
                acked = 1; rv = readvalid; rdat = readdata; rsp = resp;
                avalonWrite = 1'b0; avalonRead = 1'b0; errClear = clr;
            end
        end
        avalonWrite = 1'b0; avalonRead = 1'b0;
        @(negedge clk);
        errClear = 1'b0;
        if (clr) begin m_cnt = 0; m_st = 0; end
        else if (v.rsp != RespOkay) begin m_st = 1; if (m_cnt < 255) m_cnt++; end
        chk({tag, "_ack"}, 64'(acked), 64'(1));
        chk({tag, "_addr"}, 64'(rec_addr), 64'(v.exp_addr));
        chk({tag, "_latency"}, 64'(cyc + 1), 64'(v.exp_lat));
        chk({tag, "_resp"}, 64'(rsp), 64'(v.rsp));
        chk({tag, "_readvalid"}, 64'(rv), 64'(!v.is_wr));
        if (v.is_wr) begin
            chk({tag, "_wdata"}, 64'(rec_wdata), 64'(v.data));
            chk({tag, "_wstrb"}, 64'(rec_wstrb), 64'(v.be));
        end else begin
            chk({tag, "_rdata"}, 64'(rdat), 64'(v.exp_rdata));
        end
        chk({tag, "_handshakes"}, 64'(n_aw * 10000 + n_w * 1000 + n_b * 100 + n_ar * 10 + n_r),
            64'(v.is_wr ? 11100 : 11));
        chk({tag, "_errcount"}, 64'(err_count), 64'(m_cnt));
        chk({tag, "_errsticky"}, 64'(err_sticky), 64'(m_st));
    endtask

    task automatic dut2_read(input logic [31:0] a, input logic [31:0] exp_addr, input string tag);
        logic [31:0] seen = 'x;
        bit          done = 0;
        addr2 = a; rd2 = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (axi2.arvalid) seen = axi2.araddr;
            if (!wait2) begin
                done = 1;
                rd2 = 1'b0;
                chk({tag, "_rdata"}, rdata2, 64'h0123_4567_89AB_CDEF);
                chk({tag, "_readvalid"}, 64'(rv2), 64'(1));
            end
        end
        rd2 = 1'b0;
        chk({tag, "_ack"}, 64'(done), 64'(1));
        chk({tag, "_araddr"}, 64'(seen), 64'(exp_addr));
        @(negedge clk);
    endtask

    vec_t tbl[5];

    initial begin
        vec_t v;
        int   first, second;
        tbl[0] = '{1'b1, 32'h10, 32'hA5A5_0001, 4'hF, 0, 0, 0, 0, 0, RespOkay, 32'h0,
                   32'hC700_0010, 4, 32'h0};
        tbl[1] = '{1'b0, 32'h14, 32'h0, 4'hF, 0, 0, 0, 0, 5, RespOkay, 32'h1234_5678,
                   32'hC700_0014, 9, 32'h1234_5678};
        tbl[2] = '{1'b1, 32'h20, 32'h0BAD_F00D, 4'h3, 3, 0, 0, 0, 0, RespOkay, 32'h0,
                   32'hC700_0020, 7, 32'h0};
        tbl[3] = '{1'b1, 32'h26, 32'h7777_1111, 4'hC, 0, 3, 1, 0, 0, RespOkay, 32'h0,
                   32'hC700_0024, 8, 32'h0};
        tbl[4] = '{1'b0, 32'h30, 32'h0, 4'hF, 0, 0, 0, 1, 0, RespSlverr, 32'h5555_AAAA,
                   32'hC700_0030, 5, 32'hDEAD_BEEF};

        rst = 1'b1; avalonRead = 1'b0; avalonWrite = 1'b0; errClear = 1'b0;
        avalonAddr = '0; avalonWriteData = '0; avalonBE = '0; rd2 = 1'b0; addr2 = '0;
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
        resp_cfg = RespOkay; rdata_cfg = '0;
        repeat (3) @(negedge clk);
        chk("rst_waitreq", 64'(waitreq), 64'(1));
        chk("rst_readvalid", 64'(readvalid), 64'(0));
        chk("rst_readdata", 64'(readdata), 64'(0));
        chk("rst_resp", 64'(resp), 64'(0));
        chk("rst_valids", 64'({axi.awvalid, axi.wvalid, axi.arvalid}), 64'(0));
        chk("rst_readies", 64'({axi.bready, axi.rready}), 64'(0));
        chk("rst_prot", 64'({axi.awprot, axi.arprot}), 64'(0));
        chk("rst_err", 64'({err_sticky, err_count}), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) apply(tbl[i], 1'b0, $sformatf("tbl%0d", i));
        chk("slverr_errcount", 64'(err_count), 64'(1));
        chk("slverr_sticky", 64'(err_sticky), 64'(1));

        for (int i = 0; i < 40; i++) begin
            v.is_wr = 1'($urandom_range(0, 1));
            v.addr = $urandom; v.data = $urandom; v.be = 4'($urandom_range(1, 15));
            v.awd = int'($urandom_range(0, 3)); v.wd = int'($urandom_range(0, 3));
            v.bd = int'($urandom_range(0, 3)); v.ard = int'($urandom_range(0, 3));
            v.rd = int'($urandom_range(0, 3)); v.rdat = $urandom;
            v.rsp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : RespOkay;
            apply(with_expect(v), 1'b0, $sformatf("rnd%0d", i));
        end

        v = '{1'b1, 32'h40, 32'h1, 4'hF, 0, 0, 0, 0, 0, RespDecerr, 32'h0, 32'h0, 0, 32'h0};
        for (int i = 0; i < 300; i++) apply(with_expect(v), 1'b0, "sat");
        chk("sat_errcount", 64'(err_count), 64'(255));
        apply(with_expect(v), 1'b1, "clr_at_ack");
        chk("clr_errcount", 64'(err_count), 64'(0));
        chk("clr_sticky", 64'(err_sticky), 64'(0));

        // Command held across ACK is taken again in the very next IDLE cycle.
        aw_dly = 0; w_dly = 0; b_dly = 0; resp_cfg = RespOkay;
        n_aw = 0; n_w = 0; n_b = 0;
        avalonWrite = 1'b1; avalonAddr = 32'h50; avalonWriteData = 32'h2; avalonBE = 4'hF;
        first = -1; second = -1;
        for (int c = 1; c <= 40 && second < 0; c++) begin
            @(negedge clk);
            if (!waitreq) begin
                if (first < 0) first = c;
                else second = c;
            end
        end
        avalonWrite = 1'b0;
        @(negedge clk);
        chk("b2b_gap", 64'(second - first), 64'(4));
        chk("b2b_bcount", 64'(n_b), 64'(2));

        // Reset while waiting for read data aborts the transfer.
        ar_dly = 0; r_dly = 30;
        avalonRead = 1'b1; avalonAddr = 32'h60;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_rd_d", 64'(axi.rready), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("abort_valids", 64'({axi.awvalid, axi.wvalid, axi.arvalid}), 64'(0));
        chk("abort_readies", 64'({axi.bready, axi.rready}), 64'(0));
        chk("abort_waitreq", 64'(waitreq), 64'(1));
        chk("abort_readvalid", 64'(readvalid), 64'(0));
        avalonRead = 1'b0;
        @(negedge clk);
        rst = 1'b0; m_cnt = 0; m_st = 0;
        @(negedge clk);
        v = '{1'b0, 32'h64, 32'h0, 4'hF, 0, 0, 0, 1, 2, RespOkay, 32'hCAFE_F00D,
              32'h0, 0, 32'h0};
        apply(with_expect(v), 1'b0, "after_abort");

        dut2_read(32'h0F, 32'hFFFF_FFF8, "w64_align");
        dut2_read(32'h20, 32'h0000_0010, "w64_wrap");

        chk("valid_drop_violations", 64'(viol), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
